// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous iSig over a fixed gate window and
// reports the count with a one-cycle valid strobe, back-to-back while enabled.
//
// Ports:
//   iClk_in  system clock
//   iRst     asynchronous active-low reset
//   iSig     asynchronous signal to be measured
//   iEn      measurement enable, level-sensitive
//   oCount   edge count of the last completed window
//   oValid   one-cycle strobe: oCount/oOvf updated
//   oOvf     last completed window saturated the edge counter
//   oBusy    high while a window is in progress
module freq_meter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int GATE_W      = 20,
  parameter int CNT_W       = 16
) (
  input  logic             iClk_in,
  input  logic             iRst,
  input  logic             iSig,
  input  logic             iEn,
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
  output logic             oOvf,
  output logic             oBusy
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [GATE_W-1:0] LAST =
    GATE_W'(GATE_CYCLES - 1);

  state_t state, stateNxt;

  logic sync1, sync2, prev;
  logic sigRise;

  logic [GATE_W-1:0] gateCnt, gateNxt;
  logic [CNT_W-1:0]  edgeCnt, cntNxt, cntInc;
  logic              ovf, ovfNxt, ovfInc;
  logic              sat;
  logic              done;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge iClk_in or negedge iRst) begin
    if (!iRst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= iSig;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sigRise = sync2 & ~prev;

  // Count including this cycle's edge; used both in-window and for the
  // final result so a terminal-cycle edge is never lost.
  assign sat    = &edgeCnt;
  assign cntInc = edgeCnt + CNT_W'(sigRise & ~sat);
  assign ovfInc = ovf | (sigRise & sat);

  always_ff @(posedge iClk_in or negedge iRst) begin
    if (!iRst) begin
      state   <= IDLE;
      gateCnt <= '0;
      edgeCnt <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= stateNxt;
      gateCnt <= gateNxt;
      edgeCnt <= cntNxt;
      ovf     <= ovfNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    gateNxt  = '0;
    cntNxt   = '0;
    ovfNxt   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (iEn) stateNxt = MEAS;
      end
      MEAS: begin
        if (gateCnt == LAST) begin
          // Restart immediately when still enabled: no dead cycle.
          done     = 1'b1;
          stateNxt = iEn ? MEAS : IDLE;
        end else if (!iEn) begin
          stateNxt = IDLE;
        end else begin
          gateNxt = gateCnt + 1'b1;
          cntNxt  = cntInc;
          ovfNxt  = ovfInc;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk_in or negedge iRst) begin
    if (!iRst) begin
      oValid <= 1'b0;
      oCount <= '0;
      oOvf   <= 1'b0;
    end else begin
      oValid <= done;
      if (done) begin
        oCount <= cntInc;
        oOvf   <= ovfInc;
      end
    end
  end

  assign oBusy = (state == MEAS);

endmodule
